// File: rtl/rs232_cmd_pkg.sv
// Shared state encoding and opcodes for the RS-232 command sequencer.
// Latency: none (types and constants only).
// Backpressure: none.
package rs232_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_BUS  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R'

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WRITE) || (b == OP_READ);
  endfunction

endpackage

// File: rtl/rs232_cmd_resp.sv
// Read-data serializer: latches a bus read word and streams it out MSB byte first.
// Latency: tx_valid rises the cycle after load; one byte leaves per tx handshake.
// Backpressure: tx_data held while tx_ready is low; done pulses with the last handshake.
module rs232_cmd_resp #(
  parameter int DATA_BYTES = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [8*DATA_BYTES-1:0] load_data,
  input  logic                    tx_ready,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  output logic                    done
);

  logic [8*DATA_BYTES-1:0] shift_q;
  logic [1:0]              left_q;   // bytes remaining after the one on tx_data
  logic                    active_q;

  assign tx_valid = active_q;
  assign tx_data  = shift_q[8*DATA_BYTES-1 -: 8];
  // The final handshake is the one that completes the whole command.
  assign done     = active_q & tx_ready & (left_q == 2'd0);

  // Load the word on bus ack, then shift one byte out per accepted handshake
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      shift_q  <= '0;
      left_q   <= 2'd0;
      active_q <= 1'b0;
    end else if (load) begin
      shift_q  <= load_data;
      left_q   <= 2'(DATA_BYTES - 1);
      active_q <= 1'b1;
    end else if (active_q && tx_ready) begin
      shift_q <= shift_q << 8;
      if (left_q == 2'd0) active_q <= 1'b0;
      else                left_q   <= left_q - 2'd1;
    end
  end

endmodule

// File: rtl/rs232_cmd_ctrl.sv
// Host-link sequencer: parses 'W'/'R' frames from the UART, runs one bus transaction each, returns read data.
// Latency: bus_req the cycle after the last frame byte; reply bytes start the cycle after bus_ack.
// Backpressure: bus_req held until bus_ack; reply waits on tx_ready; bytes arriving while busy on bus/reply are dropped (overrun).
module rs232_cmd_ctrl
  import rs232_cmd_pkg::*;
#(
  parameter int ADDR_BYTES     = 2,
  parameter int DATA_BYTES     = 4,
  parameter int TIMEOUT_CYCLES = 500_000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    rx_attention,
  input  logic [7:0]              rx_data,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [8*ADDR_BYTES-1:0] bus_addr,
  output logic [8*DATA_BYTES-1:0] bus_wdata,
  input  logic                    bus_ack,
  input  logic [8*DATA_BYTES-1:0] bus_rdata,
  output logic                    tx_valid,
  output logic [7:0]              tx_data,
  input  logic                    tx_ready,
  output logic                    cmd_done,
  output logic                    frame_error,
  output logic                    overrun,
  output logic                    busy
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t                  state, state_next;
  logic [1:0]              byte_cnt;
  logic [TMO_W-1:0]        tmo_cnt;
  logic                    in_frame, tmo_expire, last_byte;
  logic                    take_op, take_addr, take_data, resp_load, resp_done;
  logic [8*ADDR_BYTES-1:0] addr_shift;
  logic [8*DATA_BYTES-1:0] wdata_shift;

  assign busy       = (state != ST_IDLE);
  assign bus_req    = (state == ST_BUS);
  assign in_frame   = (state == ST_ADDR) || (state == ST_DATA);
  // Expiry is the cycle in which the idle count would reach TIMEOUT_CYCLES.
  assign tmo_expire = in_frame && (tmo_cnt == TMO_LAST);
  assign last_byte  = (byte_cnt == 2'd0);

  // Shift the incoming byte into the LSB of the address / write-data registers
  always_comb begin
    addr_shift       = bus_addr << 8;
    addr_shift[7:0]  = rx_data;
    wdata_shift      = bus_wdata << 8;
    wdata_shift[7:0] = rx_data;
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state decode and single-cycle status pulses
  always_comb begin
    state_next  = state;
    take_op     = 1'b0;
    take_addr   = 1'b0;
    take_data   = 1'b0;
    resp_load   = 1'b0;
    cmd_done    = 1'b0;
    frame_error = 1'b0;
    overrun     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_attention) begin
          if (is_opcode(rx_data)) begin
            take_op    = 1'b1;
            state_next = ST_ADDR;
          end else begin
            frame_error = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        // A byte landing in the expiry cycle takes priority over the timeout.
        if (rx_attention) begin
          take_addr = 1'b1;
          if (last_byte) state_next = bus_we ? ST_DATA : ST_BUS;
        end else if (tmo_expire) begin
          frame_error = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (rx_attention) begin
          take_data = 1'b1;
          if (last_byte) state_next = ST_BUS;
        end else if (tmo_expire) begin
          frame_error = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      ST_BUS: begin
        overrun = rx_attention;
        if (bus_ack) begin
          if (bus_we) begin
            cmd_done   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            resp_load  = 1'b1;
            state_next = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        overrun = rx_attention;
        if (resp_done) begin
          cmd_done   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Frame capture: direction, address, write data and the per-field byte counter
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      byte_cnt  <= 2'd0;
    end else begin
      if (take_op) begin
        bus_we   <= (rx_data == OP_WRITE);
        byte_cnt <= 2'(ADDR_BYTES - 1);
      end
      if (take_addr) begin
        bus_addr <= addr_shift;
        byte_cnt <= last_byte ? 2'(DATA_BYTES - 1) : byte_cnt - 2'd1;
      end
      if (take_data) begin
        bus_wdata <= wdata_shift;
        byte_cnt  <= byte_cnt - 2'd1;
      end
    end
  end

  // Inter-byte timer: restarts on every byte, runs only while a frame is partial
  always_ff @(posedge clock) begin
    if (!reset_n)                     tmo_cnt <= '0;
    else if (rx_attention || !in_frame) tmo_cnt <= '0;
    else                              tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  rs232_cmd_resp #(
    .DATA_BYTES(DATA_BYTES)
  ) u_resp (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (resp_load),
    .load_data(bus_rdata),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .done     (resp_done)
  );

endmodule

// File: tb/tb_rs232_cmd_ctrl.sv
// Bench for rs232_cmd_ctrl: directed frames against a queue-based transaction model.
// Latency: model predicts every output cycle by cycle from the bench-driven inputs.
// Backpressure: bus ack delay and tx_ready stall are programmable per scenario.
module tb_rs232_cmd_ctrl;

  localparam int AB  = 2;
  localparam int DB  = 4;
  localparam int TMO = 100;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_attention = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        bus_req, bus_we;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        cmd_done, frame_error, overrun, busy;

  int checks = 0;
  int failures = 0;

  rs232_cmd_ctrl #(
    .ADDR_BYTES(AB), .DATA_BYTES(DB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .rx_attention(rx_attention), .rx_data(rx_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .cmd_done(cmd_done), .frame_error(frame_error),
    .overrun(overrun), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- bus responder and transmitter sink ----------------
  int          ack_delay = 3;
  int          tx_stall = 0;
  logic [31:0] next_rdata = 32'h0;

  initial begin : responder
    int wait_cnt = 0;
    forever begin
      @(posedge clock); #1;
      if (bus_ack) bus_ack = 1'b0;
      else if (bus_req === 1'b1) begin
        if (wait_cnt >= ack_delay) begin
          bus_ack = 1'b1; bus_rdata = next_rdata; wait_cnt = 0;
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  initial begin : sink
    int st_cnt = 0;
    forever begin
      @(posedge clock); #1;
      if (tx_valid === 1'b1) begin
        if (st_cnt >= tx_stall) begin tx_ready = 1'b1; st_cnt = 0; end
        else begin tx_ready = 1'b0; st_cnt++; end
      end else begin
        tx_ready = 1'b0; st_cnt = 0;
      end
    end
  end

  // ---------------- model and per-cycle compare ----------------
  bit          chk_en = 1'b0;
  logic [7:0]  m_frame[$];
  logic [7:0]  m_reply[$];
  bit          m_req = 1'b0, m_we = 1'b0;
  logic [15:0] m_addr = 16'h0;
  logic [31:0] m_wdata = 32'h0;
  int          m_idle = 0;
  bit          e_busy, e_req, e_txv, e_done, e_ferr, e_ovr;
  logic [7:0]  e_txd;

  // Observation log used by the literal end-of-scenario checks
  int          n_req = 0, n_done = 0, n_ferr = 0, n_ovr = 0;
  bit          prev_req = 1'b0;
  logic        log_we;
  logic [15:0] log_addr;
  logic [31:0] log_wdata;
  logic [7:0]  tx_log[$];

  always @(negedge clock) begin
    if (chk_en) begin
      e_busy = (m_frame.size() != 0) || m_req || (m_reply.size() != 0);
      e_req  = m_req;
      e_txv  = (m_reply.size() != 0);
      e_txd  = e_txv ? m_reply[0] : 8'h00;
      e_done = 1'b0; e_ferr = 1'b0; e_ovr = 1'b0;
      chk("busy", busy, e_busy);
      chk("bus_req", bus_req, e_req);
      chk("tx_valid", tx_valid, e_txv);
      if (e_req) begin
        chk("bus_we", bus_we, m_we);
        chk("bus_addr", bus_addr, m_addr);
        chk("bus_wdata", bus_wdata, m_wdata);
      end
      if (e_txv) chk("tx_data", tx_data, e_txd);
      // Reply byte accepted; the last one completes a read
      if (e_txv && tx_ready) begin
        void'(m_reply.pop_front());
        if (m_reply.size() == 0) e_done = 1'b1;
      end
      // Bus transaction ends: writes are done, reads queue the reply MSB first
      if (e_req && bus_ack) begin
        if (m_we) e_done = 1'b1;
        else for (int i = DB - 1; i >= 0; i--) m_reply.push_back(bus_rdata[8*i +: 8]);
        m_req = 1'b0;
      end
      // Incoming byte: dropped while a transaction is in flight, else parsed
      if (rx_attention) begin
        m_idle = 0;
        if (e_req || e_txv) e_ovr = 1'b1;
        else if (m_frame.size() == 0 && rx_data != 8'h57 && rx_data != 8'h52) e_ferr = 1'b1;
        else begin
          m_frame.push_back(rx_data);
          if ((m_frame[0] == 8'h57 && m_frame.size() == 1 + AB + DB) ||
              (m_frame[0] == 8'h52 && m_frame.size() == 1 + AB)) begin
            m_we   = (m_frame[0] == 8'h57);
            m_addr = {m_frame[1], m_frame[2]};
            if (m_we) m_wdata = {m_frame[3], m_frame[4], m_frame[5], m_frame[6]};
            m_req  = 1'b1;
            m_frame.delete();
          end
        end
      end else if (m_frame.size() != 0) begin
        m_idle++;
        if (m_idle == TMO) begin
          e_ferr = 1'b1; m_frame.delete(); m_idle = 0;
        end
      end
      chk("cmd_done", cmd_done, e_done);
      chk("frame_error", frame_error, e_ferr);
      chk("overrun", overrun, e_ovr);

      if (bus_req && !prev_req) begin
        n_req++; log_we = bus_we; log_addr = bus_addr; log_wdata = bus_wdata;
      end
      prev_req = bus_req;
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
      n_done += int'(cmd_done);
      n_ferr += int'(frame_error);
      n_ovr  += int'(overrun);

      if (!reset_n) begin
        m_frame.delete(); m_reply.delete();
        m_req = 1'b0; m_we = 1'b0; m_addr = 16'h0; m_wdata = 32'h0; m_idle = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_attention = 1'b1; rx_data = b;
    step(1);
    rx_attention = 1'b0;
  endtask

  task automatic send_read(input logic [15:0] a);
    send_byte(8'h52); send_byte(a[15:8]); send_byte(a[7:0]);
  endtask

  task automatic send_write(input logic [15:0] a, input logic [31:0] d);
    send_byte(8'h57); send_byte(a[15:8]); send_byte(a[7:0]);
    for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin step(1); n++; end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s: busy still %b after %0d cycles, need 0", name, busy, budget);
    end
  endtask

  task automatic chk_reply(input string name, input int base, input logic [31:0] exp);
    chk({name, " bytes"}, tx_log.size() - base, DB);
    for (int i = 0; i < DB; i++)
      if (base + i < tx_log.size()) chk(name, tx_log[base + i], exp[8*(DB-1-i) +: 8]);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int base;
    int n;
    step(3);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    @(negedge clock);
    chk("rst bus_req", bus_req, 0);     chk("rst bus_we", bus_we, 0);
    chk("rst bus_addr", bus_addr, 0);   chk("rst bus_wdata", bus_wdata, 0);
    chk("rst tx_valid", tx_valid, 0);   chk("rst tx_data", tx_data, 0);
    chk("rst cmd_done", cmd_done, 0);   chk("rst frame_error", frame_error, 0);
    chk("rst overrun", overrun, 0);     chk("rst busy", busy, 0);
    step(1);

    // Write 1234 <- DEADBEEF, ack after 3 wait cycles
    ack_delay = 3;
    send_write(16'h1234, 32'hDEADBEEF);
    chk("wr req next cycle", bus_req, 1);
    wait_idle("wr idle", 50);
    chk("wr req count", n_req, 1);
    chk("wr we", log_we, 1);
    chk("wr addr", log_addr, 16'h1234);
    chk("wr wdata", log_wdata, 32'hDEADBEEF);
    chk("wr done count", n_done, 1);
    chk("wr no tx", tx_log.size(), 0);

    // Read 0010 -> 01020304 with 5-cycle transmitter stalls
    tx_stall = 5; next_rdata = 32'h01020304; base = tx_log.size();
    send_read(16'h0010);
    wait_idle("rd idle", 200);
    chk("rd we", log_we, 0);
    chk("rd addr", log_addr, 16'h0010);
    chk_reply("rd reply", base, 32'h01020304);
    chk("rd done count", n_done, 2);

    // Bad opcode, then a read with a single-cycle bus transaction
    send_byte(8'h41);
    chk("badop ferr", n_ferr, 1);
    chk("badop no req", n_req, 2);
    chk("badop busy", busy, 0);
    ack_delay = 0; tx_stall = 0; next_rdata = 32'h0A0B0C0D; base = tx_log.size();
    send_read(16'h0010);
    wait_idle("rd2 idle", 50);
    chk_reply("rd2 reply", base, 32'h0A0B0C0D);

    // Inter-byte timeout: error lands on the 100th idle cycle
    send_byte(8'h57); send_byte(8'h12);
    step(TMO - 2);
    @(negedge clock);
    chk("tmo busy at 99", busy, 1);
    chk("tmo no err at 99", frame_error, 0);
    step(1);
    @(negedge clock);
    chk("tmo err at 100", frame_error, 1);
    step(1);
    @(negedge clock);
    chk("tmo busy after", busy, 0);
    chk("tmo ferr count", n_ferr, 2);
    step(1);

    // Byte on the expiry cycle is accepted and the frame completes
    ack_delay = 2;
    send_byte(8'h57); send_byte(8'h12);
    step(TMO - 1);
    send_byte(8'h56);
    for (int i = 3; i >= 0; i--) begin
      logic [31:0] d;
      d = 32'hCAFEF00D;
      send_byte(d[8*i +: 8]);
    end
    wait_idle("exp idle", 50);
    chk("exp no ferr", n_ferr, 2);
    chk("exp addr", log_addr, 16'h1256);
    chk("exp wdata", log_wdata, 32'hCAFEF00D);
    chk("exp we", log_we, 1);

    // Overrun during the bus wait and during the reply
    ack_delay = 6; tx_stall = 3; next_rdata = 32'h11223344; base = tx_log.size();
    send_read(16'h0020);
    send_byte(8'h99);
    n = 0;
    while (tx_valid !== 1'b1 && n < 50) begin step(1); n++; end
    chk("ovr reply started", tx_valid, 1);
    send_byte(8'h77);
    wait_idle("ovr idle", 100);
    chk("ovr count", n_ovr, 2);
    chk("ovr addr", log_addr, 16'h0020);
    chk_reply("ovr reply", base, 32'h11223344);

    // Reset after two reply bytes, then a clean read
    tx_stall = 2; next_rdata = 32'hA1B2C3D4; base = tx_log.size();
    send_read(16'h0030);
    n = 0;
    while (tx_log.size() < base + 2 && n < 100) begin step(1); n++; end
    chk("rstmid bytes before", tx_log.size() - base, 2);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rstmid tx_valid", tx_valid, 0);
    chk("rstmid bus_req", bus_req, 0);
    chk("rstmid busy", busy, 0);
    step(1);
    tx_stall = 1; next_rdata = 32'h55667788; base = tx_log.size();
    send_read(16'h0040);
    wait_idle("post idle", 100);
    chk("post addr", log_addr, 16'h0040);
    chk_reply("post reply", base, 32'h55667788);
    chk("total done", n_done, 6);
    chk("total ferr", n_ferr, 2);

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

endmodule
